// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two ALU requesters and
// the ALU arbiter.
//   req_valid[k] / req_ready[k]  request handshake for requester k
//   reqK_a, reqK_b, reqK_op      requester K operands and opcode
//   resp_valid[k] / resp_ready[k] response handshake (resp_valid is one-hot)
//   resp_result, resp_z/c/n      registered ALU result and flags
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int DATA_BUS_WIDTH  = 16,
    parameter int ALU_OP_NUM_BITS = 2
);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [DATA_BUS_WIDTH-1:0]  req0_a;
    logic [DATA_BUS_WIDTH-1:0]  req0_b;
    logic [ALU_OP_NUM_BITS-1:0] req0_op;
    logic [DATA_BUS_WIDTH-1:0]  req1_a;
    logic [DATA_BUS_WIDTH-1:0]  req1_b;
    logic [ALU_OP_NUM_BITS-1:0] req1_op;
    logic [1:0]                 resp_valid;
    logic [1:0]                 resp_ready;
    logic [DATA_BUS_WIDTH-1:0]  resp_result;
    logic                       resp_z;
    logic                       resp_c;
    logic                       resp_n;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output resp_ready,
        input  req_ready, resp_valid, resp_result, resp_z, resp_c, resp_n
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  resp_ready,
        output req_ready, resp_valid, resp_result, resp_z, resp_c, resp_n
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// round-robin arbitration. One operation in flight at a time; operands are
// registered before driving the ALU and the result/flags are registered
// before being returned on a one-hot response handshake.
//   clk, reset                 clock (rising edge), async active-high reset
//   bus (slave)                request/response handshakes, see alu_arbiter_if
//   alu_a, alu_b, alu_op       ALU operand/opcode drive (from operand regs)
//   alu_result, alu_z/c/n      ALU result and flags, captured at end of EXEC
//
// state | meaning
// IDLE  | arbitrating; req_ready driven for the granted requester
// EXEC  | operand regs drive the ALU for one cycle; result captured at exit
// RESP  | resp_valid to the owner until it accepts
module alu_arbiter #(
    parameter int DATA_BUS_WIDTH  = 16,
    parameter int ALU_OP_NUM_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    alu_arbiter_if.slave               bus,
    output logic [DATA_BUS_WIDTH-1:0]  alu_a,
    output logic [DATA_BUS_WIDTH-1:0]  alu_b,
    output logic [ALU_OP_NUM_BITS-1:0] alu_op,
    input  logic [DATA_BUS_WIDTH-1:0]  alu_result,
    input  logic                       alu_z,
    input  logic                       alu_c,
    input  logic                       alu_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic                       last_grant;
    logic                       owner_id;
    logic [DATA_BUS_WIDTH-1:0]  opnd_a;
    logic [DATA_BUS_WIDTH-1:0]  opnd_b;
    logic [ALU_OP_NUM_BITS-1:0] opnd_op;
    logic [DATA_BUS_WIDTH-1:0]  res_result;
    logic                       res_z;
    logic                       res_c;
    logic                       res_n;

    logic       grant_valid;
    logic       grant_id;
    logic       accept;
    logic       resp_done;
    logic [1:0] req_ready_int;
    logic [1:0] resp_valid_int;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_id    = ~last_grant;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_id    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A grant always targets a valid requester, so req_ready high implies
    // the handshake completes on this edge. reset gates req_ready because
    // the grant logic is otherwise live while the state is held in IDLE.
    always_comb begin
        state_next     = state;
        req_ready_int  = 2'b00;
        resp_valid_int = 2'b00;
        accept         = 1'b0;
        resp_done      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && !reset) begin
                    req_ready_int[grant_id] = 1'b1;
                    accept                  = 1'b1;
                    state_next              = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid_int[owner_id] = 1'b1;
                if (bus.resp_ready[owner_id]) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner_id   <= 1'b0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            opnd_op    <= '0;
            res_result <= '0;
            res_z      <= 1'b0;
            res_c      <= 1'b0;
            res_n      <= 1'b0;
        end else begin
            if (accept) begin
                owner_id <= grant_id;
                opnd_a   <= grant_id ? bus.req1_a  : bus.req0_a;
                opnd_b   <= grant_id ? bus.req1_b  : bus.req0_b;
                opnd_op  <= grant_id ? bus.req1_op : bus.req0_op;
            end
            if (state == EXEC) begin
                res_result <= alu_result;
                res_z      <= alu_z;
                res_c      <= alu_c;
                res_n      <= alu_n;
            end
            if (resp_done) begin
                last_grant <= owner_id;
            end
        end
    end

    // Operand regs feed the ALU directly; they only change at an accept,
    // so the drive is stable through EXEC and clears with reset.
    assign alu_a  = opnd_a;
    assign alu_b  = opnd_b;
    assign alu_op = opnd_op;

    assign bus.req_ready   = req_ready_int;
    assign bus.resp_valid  = resp_valid_int;
    assign bus.resp_result = res_result;
    assign bus.resp_z      = res_z;
    assign bus.resp_c      = res_c;
    assign bus.resp_n      = res_n;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// behavioural model (plain integer arithmetic for the ALU results, a
// "served last loses ties" rule for arbitration).
module tb_alu_arbiter;
    localparam int W = 16;
    localparam int OPW = 2;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   alu_a, alu_b, alu_result;
    logic [OPW-1:0] alu_op;
    logic           alu_z, alu_c, alu_n;
    logic [W:0]     alu_wide;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int last_served;
    logic [1:0] pending;
    logic [W-1:0]   cur_a [2];
    logic [W-1:0]   cur_b [2];
    logic [OPW-1:0] cur_op[2];

    alu_arbiter_if #(.DATA_BUS_WIDTH(W), .ALU_OP_NUM_BITS(OPW)) bus ();

    alu_arbiter #(.DATA_BUS_WIDTH(W), .ALU_OP_NUM_BITS(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_n      (alu_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared combinational ALU seen by the arbiter.
    always_comb begin
        alu_wide = '0;
        case (alu_op)
            OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
            default: alu_wide = '0;
        endcase
        alu_result = alu_wide[W-1:0];
        alu_c      = alu_wide[W];
        alu_z      = (alu_wide[W-1:0] == '0);
        alu_n      = alu_wide[W-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_alu(input int a, input int b, input int op,
                                    output logic [15:0] r, output logic z,
                                    output logic c, output logic n);
        int s;
        case (op)
            0: begin s = a + b; c = (s > 65535); end
            1: begin s = a - b; c = (a >= b); if (s < 0) s = s + 65536; end
            default: begin s = 0; c = 1'b0; end
        endcase
        s = s % 65536;
        r = 16'(s);
        z = (s == 0);
        n = (s >= 32768);
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic run_op(input logic [1:0] valids, input int stall);
        int w;
        logic [1:0] oh;
        logic [15:0] er;
        logic ez, ec, en;
        bus.req_valid  = valids;
        bus.req0_a     = cur_a[0];
        bus.req0_b     = cur_b[0];
        bus.req0_op    = cur_op[0];
        bus.req1_a     = cur_a[1];
        bus.req1_b     = cur_b[1];
        bus.req1_op    = cur_op[1];
        bus.resp_ready = 2'b11;
        if (valids == 2'b01)      w = 0;
        else if (valids == 2'b10) w = 1;
        else                      w = (last_served == 0) ? 1 : 0;
        oh = (w == 0) ? 2'b01 : 2'b10;
        ref_alu(int'(cur_a[w]), int'(cur_b[w]), int'(cur_op[w]), er, ez, ec, en);
        #1;
        check("grant_ready", 32'(bus.req_ready), 32'(oh));
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        check("exec_req_ready", 32'(bus.req_ready), 32'd0);
        check("exec_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("exec_alu_a", 32'(alu_a), 32'(cur_a[w]));
        check("exec_alu_b", 32'(alu_b), 32'(cur_b[w]));
        check("exec_alu_op", 32'(alu_op), 32'(cur_op[w]));
        pending = valids & ~oh;
        bus.req_valid = pending;
        if (w == 0) begin
            bus.req0_a = ~cur_a[0]; bus.req0_b = cur_a[0] ^ 16'h5A5A; bus.req0_op = ~cur_op[0];
        end else begin
            bus.req1_a = ~cur_a[1]; bus.req1_b = cur_a[1] ^ 16'h5A5A; bus.req1_op = ~cur_op[1];
        end
        @(posedge clk);
        @(negedge clk);
        check("resp_valid", 32'(bus.resp_valid), 32'(oh));
        check("resp_result", 32'(bus.resp_result), 32'(er));
        check("resp_flags", {29'd0, bus.resp_z, bus.resp_c, bus.resp_n}, {29'd0, ez, ec, en});
        for (int i = 0; i < stall; i++) begin
            bus.resp_ready = ~oh;
            @(posedge clk);
            @(negedge clk);
            check("stall_resp_valid", 32'(bus.resp_valid), 32'(oh));
            check("stall_result", 32'(bus.resp_result), 32'(er));
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 2'b11;
        @(posedge clk);
        last_served = w;
        @(negedge clk);
        check("post_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("post_req_ready", 32'(bus.req_ready), 32'(pending));
    endtask

    task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        cur_a[k] = a;
        cur_b[k] = b;
        cur_op[k] = op;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int prev_acc;
        logic [1:0] v;
        reset          = 1'b1;
        last_served    = 1;
        pending        = 2'b00;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b00;
        bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_op = OP_ADD;
        bus.req1_a = 16'h3333; bus.req1_b = 16'h4444; bus.req1_op = OP_SUB;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_result", 32'(bus.resp_result), 32'd0);
        check("rst_flags", {29'd0, bus.resp_z, bus.resp_c, bus.resp_n}, 32'd0);
        check("rst_alu", {alu_op, alu_a[13:0], alu_b}, 32'd0);
        reset = 1'b0;
        bus.req_valid = 2'b00;

        // Tie after reset: grants alternate 0,1,0,1, one accept per 3 cycles.
        set_req(0, 16'h0010, 16'h0020, OP_ADD);
        set_req(1, 16'h0100, 16'h0001, OP_SUB);
        run_op(2'b11, 0);
        prev_acc = acc_cyc;
        for (int i = 0; i < 3; i++) begin
            run_op(2'b11, 0);
            check("tie_spacing", 32'(acc_cyc - prev_acc), 32'd3);
            prev_acc = acc_cyc;
        end
        run_op(pending, 0);

        set_req(0, 16'h0003, 16'h0004, OP_ADD);
        run_op(2'b01, 0);
        set_req(0, 16'hFFFF, 16'h0001, OP_ADD);
        run_op(2'b01, 0);
        set_req(0, 16'h7FFF, 16'h0001, OP_ADD);
        run_op(2'b01, 0);
        set_req(1, 16'h0005, 16'h0005, OP_SUB);
        run_op(2'b10, 0);
        set_req(1, 16'h0003, 16'h0005, OP_SUB);
        run_op(2'b10, 1);

        // Backpressure with req1 pending: req0 wins the tie, then req1.
        set_req(0, 16'h1234, 16'h1111, OP_SUB);
        set_req(1, 16'h4000, 16'h4000, OP_ADD);
        run_op(2'b11, 5);
        run_op(pending, 0);

        // Unsupported opcode passes through; ALU returns zero.
        set_req(1, 16'hABCD, 16'h1234, 2'd3);
        run_op(2'b10, 0);

        // Reset during EXEC aborts the operation.
        set_req(0, 16'hBEEF, 16'h0101, OP_ADD);
        set_req(1, 16'hCAFE, 16'h0202, OP_SUB);
        bus.req_valid = 2'b11;
        bus.req0_a = cur_a[0]; bus.req0_b = cur_b[0]; bus.req0_op = cur_op[0];
        bus.req1_a = cur_a[1]; bus.req1_b = cur_b[1]; bus.req1_op = cur_op[1];
        bus.resp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_alu_a", 32'(alu_a), 32'(cur_a[last_served == 0 ? 1 : 0]));
        reset = 1'b1;
        #1;
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_alu_a", 32'(alu_a), 32'd0);
        check("midrst_alu_b", 32'(alu_b), 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_served = 1;
        pending = 2'b00;
        bus.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_resp", 32'(bus.resp_valid), 32'd0);
        end
        run_op(2'b11, 0);
        run_op(pending, 0);

        // Randomized traffic; a pending requester keeps its request unchanged.
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3)) | pending;
            for (int k = 0; k < 2; k++) begin
                if (v[k] && !pending[k]) begin
                    set_req(k, rand_val(), rand_val(), 2'($urandom_range(0, 3)));
                end
            end
            run_op(v, int'($urandom_range(0, 2)));
            if (pending == 2'b00 && $urandom_range(0, 3) == 0) begin
                bus.req_valid = 2'b00;
                #1;
                check("idle_req_ready", 32'(bus.req_ready), 32'd0);
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (pending != 2'b00) run_op(pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
